// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: data width and FSM state encoding.
package inst_loader_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/inst_loader_if.sv
// UART byte stream and core instruction-fetch port of the loader.
interface inst_loader_if #(
  parameter int unsigned WIDTH = inst_loader_pkg::WIDTH
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] program_counter;
  logic [WIDTH-1:0] instr;

  modport master (
    output rx_data, rx_valid, program_counter,
    input  rx_ready, instr
  );

  modport slave (
    input  rx_data, rx_valid, program_counter,
    output rx_ready, instr
  );
endinterface

// File: rtl/inst_loader_word_assembler.sv
// Packs accepted bytes MSB-first into a word; word/word_done are valid in the cycle of the 4th byte.
module word_assembler #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              accept,
  input  logic [BYTE_W-1:0] data,
  output logic [WIDTH-1:0]  word,
  output logic              word_done
);
  localparam int unsigned SHIFT_W = WIDTH - BYTE_W;

  logic [SHIFT_W-1:0] shift_q;
  logic [1:0]         byte_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q  <= '0;
      byte_idx <= '0;
    end else if (accept) begin
      shift_q  <= {shift_q[SHIFT_W-BYTE_W-1:0], data};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Current byte is folded in directly so the full word is usable on its accepting edge.
  assign word      = {shift_q, data};
  assign word_done = accept && (byte_idx == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed program from the UART into instruction memory, then serves core fetches.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WIDTH  = inst_loader_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rstn,
  inst_loader_if.slave       bus,
  output logic               cpu_rstn,
  output logic               loading,
  output logic               err
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [WIDTH:0] MAX_N = (WIDTH+1)'(1) << ADDR_W;

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   count;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   word;
  logic               word_done;
  logic               accept;
  logic               last_word;
  logic               mem_we;
  logic [WIDTH-1:0]   mem [DEPTH];

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign last_word = (WIDTH'(wr_addr) == (count - WIDTH'(1)));
  assign mem_we    = (state == ST_LOAD) && word_done;

  word_assembler #(.WIDTH(WIDTH), .BYTE_W(BYTE_W)) u_asm (
    .clk       (clk),
    .rstn      (rstn),
    .accept    (accept),
    .data      (bus.rx_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_HDR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR: begin
        if (word_done) begin
          if (word == '0)                 state_nxt = ST_RUN;
          else if ({1'b0, word} > MAX_N)  state_nxt = ST_ERR;
          else                            state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: if (word_done && last_word) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_ERR;
    endcase
  end

  always_comb begin
    bus.rx_ready = 1'b0;
    loading      = 1'b0;
    err          = 1'b0;
    case (state)
      ST_HDR, ST_LOAD: begin
        bus.rx_ready = 1'b1;
        loading      = 1'b1;
      end
      ST_ERR:  err = 1'b1;
      default: ;
    endcase
  end

  // Header latch and write pointer; wr_addr stops at N-1 so a full-depth load never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count   <= '0;
      wr_addr <= '0;
    end else if (word_done) begin
      if (state == ST_HDR) begin
        count   <= word;
        wr_addr <= '0;
      end else if (state == ST_LOAD && !last_word) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cpu_rstn <= 1'b0;
    else       cpu_rstn <= (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= word;
  end

  // Full-width range check hides both unloaded words and stale contents from a previous load.
  always_comb begin
    bus.instr = '0;
    if (state == ST_RUN && bus.program_counter < count)
      bus.instr = mem[bus.program_counter[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed byte streams, a fetch table and random programs.
module tb_inst_loader;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp;
  } fetch_vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic cpu_rstn, loading, err;

  inst_loader_if #(.WIDTH(WIDTH)) bus ();

  inst_loader #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .cpu_rstn (cpu_rstn),
    .loading  (loading),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_pass    = 0;
  int          n_accepts = 0;
  logic [31:0] model_mem[$];
  fetch_vec_t  tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Reference fetch: a word is visible only if its index is below the loaded count.
  function automatic logic [31:0] model_fetch(input logic [31:0] pc);
    if (pc < 32'(model_mem.size())) return model_mem[pc];
    return 32'h0;
  endfunction

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    check({tag, "_rst_cpu_rstn"}, 32'(cpu_rstn), 32'd0);
    check({tag, "_rst_loading"},  32'(loading),  32'd1);
    check({tag, "_rst_err"},      32'(err),      32'd0);
    check({tag, "_rst_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    check({tag, "_rst_instr"},    bus.instr,     32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    for (int i = 0; i < gap; i++) begin
      bus.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.rx_ready) begin
      check("accept_timeout", 32'(bus.rx_ready), 32'd1);
    end else begin
      @(posedge clk);
      n_accepts++;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 one idle cycle per byte, 2 random idle cycles.
  task automatic send_program(input int gap_mode, input string tag);
    logic [31:0] n;
    logic [31:0] w;
    logic [7:0]  bytes[$];
    int          gap;
    n = 32'(model_mem.size());
    bytes = {};
    for (int s = 3; s >= 0; s--) bytes.push_back(n[s*8 +: 8]);
    foreach (model_mem[k]) begin
      w = model_mem[k];
      for (int s = 3; s >= 0; s--) bytes.push_back(w[s*8 +: 8]);
    end
    n_accepts = 0;
    foreach (bytes[i]) begin
      if (i == bytes.size() - 1) check({tag, "_loading_before_last"}, 32'(loading), 32'd1);
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
      send_byte(bytes[i], gap);
    end
    check({tag, "_accepts"},  32'(n_accepts), 32'(4 + 4 * model_mem.size()));
    check({tag, "_run_loading"}, 32'(loading), 32'd0);
    check({tag, "_run_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_run_err"}, 32'(err), 32'd0);
    check({tag, "_cpu_rstn_lag"}, 32'(cpu_rstn), 32'd0);
    @(negedge clk);
    check({tag, "_cpu_rstn_up"}, 32'(cpu_rstn), 32'd1);
  endtask

  task automatic fetch_check(input string name, input logic [31:0] pc);
    @(negedge clk);
    bus.program_counter = pc;
    #1;
    check(name, bus.instr, model_fetch(pc));
  endtask

  initial begin
    logic [31:0] pc;
    int          n;
    logic        bad;

    tbl[0] = '{32'h0000_0000, 32'h1234_5678};
    tbl[1] = '{32'h0000_0001, 32'h9ABC_DEF0};
    tbl[2] = '{32'h0000_0002, 32'h0000_0000};
    tbl[3] = '{32'h0000_1000, 32'h0000_0000};
    tbl[4] = '{32'h0000_1001, 32'h0000_0000};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000};

    rstn = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.program_counter = '0;
    pulse_reset("init");

    // Two-word program, continuous and then gapped byte stream.
    for (int pass = 0; pass < 2; pass++) begin
      model_mem = {32'h1234_5678, 32'h9ABC_DEF0};
      send_program(pass, pass == 0 ? "t1" : "t2");
      foreach (tbl[i]) begin
        @(negedge clk);
        bus.program_counter = tbl[i].pc;
        #1;
        check($sformatf("tbl%0d_pass%0d", i, pass), bus.instr, tbl[i].exp);
      end
      pulse_reset(pass == 0 ? "t1" : "t2");
    end

    // Bytes offered in RUN are refused and leave the loaded program untouched.
    model_mem = {32'h1234_5678, 32'h9ABC_DEF0};
    send_program(0, "t2b");
    bus.rx_data = 8'h55;
    bus.rx_valid = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      bad |= bus.rx_ready | loading;
    end
    bus.rx_valid = 1'b0;
    check("run_refuses_bytes", 32'(bad), 32'd0);
    fetch_check("run_hold_pc0", 32'h0);

    // Empty program: RUN right after header, stale memory hidden.
    pulse_reset("t3");
    model_mem = {};
    send_program(0, "t3");
    fetch_check("n0_pc0", 32'h0);
    fetch_check("n0_pc1", 32'h1);

    // Oversized header locks into ERROR until rstn.
    pulse_reset("t4");
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    check("err_flag", 32'(err), 32'd1);
    check("err_loading", 32'(loading), 32'd0);
    bad = 1'b0;
    bus.rx_valid = 1'b1;
    repeat (100) begin
      @(negedge clk);
      bad |= cpu_rstn | bus.rx_ready | ~err;
    end
    bus.rx_valid = 1'b0;
    check("err_hold_100", 32'(bad), 32'd0);
    bus.program_counter = '0;
    #1;
    check("err_instr", bus.instr, 32'd0);
    pulse_reset("t4x");
    @(negedge clk);
    check("err_exit_loading", 32'(loading), 32'd1);
    check("err_exit_err", 32'(err), 32'd0);

    // Abort a load after 6 bytes, then a fresh one-word program.
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pulse_reset("t5");
    model_mem = {32'hCAFE_BABE};
    send_program(0, "t5");
    fetch_check("abort_pc0", 32'h0);
    fetch_check("abort_pc1", 32'h1);

    // Largest legal program fills every address.
    pulse_reset("t6");
    model_mem = {};
    for (int k = 0; k < int'(DEPTH); k++) model_mem.push_back($urandom);
    send_program(0, "t6");
    fetch_check("full_pc0", 32'h0);
    fetch_check("full_pc_last", 32'(DEPTH - 1));
    fetch_check("full_pc_depth", 32'(DEPTH));
    fetch_check("full_pc_mid", 32'(DEPTH / 2));
    for (int k = 0; k < 8; k++) fetch_check("full_rand", 32'($urandom_range(0, DEPTH - 1)));

    // Random programs with random gaps and random fetch addresses.
    for (int it = 0; it < 4; it++) begin
      pulse_reset("t7");
      n = int'($urandom_range(1, 24));
      model_mem = {};
      for (int k = 0; k < n; k++) model_mem.push_back($urandom);
      send_program(2, "t7");
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 2))
          0:       pc = 32'($urandom_range(0, n - 1));
          1:       pc = 32'($urandom_range(0, n + 4));
          default: pc = $urandom;
        endcase
        fetch_check($sformatf("rand_it%0d_pc%08h", it, pc), pc);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
